op_engine: RTL
==============

Name: op_engine

Overview:
- Parametrised successor of the two-operand memory operation block.
- Walks N elements of two operand memories and applies a run-time selectable ALU operation to each element pair.
- Writes each result to the result memory.
- Streams every write as a commit record over a valid/ready port, so the DPI co-simulation checker compares each commit as it happens instead of polling memory after fixed delays.
- Sits between the operand memories, result_mem and the checker interface.

Parameters:
- MEM_WIDTH, 32, data width of operands and results.
- MEM_DEPTH, 8, depth of all memories; need not be a power of two.
- AW, $clog2(MEM_DEPTH) (derived, localparam), address width.
- LW, $clog2(MEM_DEPTH+1) (derived, localparam), width of the element-count field.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- op_i  in  2  operation select: 0 ADD, 1 SUB, 2 AND, 3 XOR.
- len_i  in  LW  number of elements to process.
- operand1_addr_o  out  AW  read address for operand memory 1.
- operand2_addr_o  out  AW  read address for operand memory 2.
- operand1_i  in  MEM_WIDTH  combinational read data for operand1_addr_o.
- operand2_i  in  MEM_WIDTH  combinational read data for operand2_addr_o.
- result_we_o  out  1  result memory write strobe.
- result_addr_o  out  AW  result write address.
- result_o  out  MEM_WIDTH  result write data.
- commit_valid_o  out  1  commit record valid.
- commit_ready_i  in  1  checker ready.
- commit_idx_o  out  AW  element index of the commit.
- commit_data_o  out  MEM_WIDTH  committed result.
- busy_o  out  1  high when the state is not IDLE.
- done_o  out  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset (async assert, sync release): state=IDLE; idx=0; all outputs 0; op/len registers 0. A reset mid-run aborts immediately with no further write or commit.
- States: IDLE, FETCH, COMMIT, DONE.
- IDLE:
  - start_i=1 latches op_i into op_q.
  - It latches min(len_i, MEM_DEPTH) into len_q.
  - It sets idx=0.
  - Next state is FETCH if len_q≠0, else DONE.
- FETCH:
  - operand1_addr_o = operand2_addr_o = idx.
  - At the clock edge, res_q <= alu(op_q, operand1_i, operand2_i). Next state is COMMIT.
- COMMIT:
  - result_addr_o = commit_idx_o = idx.
  - result_o = commit_data_o = res_q.
  - result_we_o=1 only in the first COMMIT cycle, so there is exactly one write per element even under backpressure.
  - commit_valid_o=1 for every COMMIT cycle. commit_idx_o and commit_data_o stay stable until the handshake.
  - On commit_valid_o && commit_ready_i: if idx==len_q-1, next state is DONE; otherwise idx++ and next state is FETCH.
- DONE: done_o=1 for one cycle, then IDLE. A new start_i is accepted on the cycle after DONE.
- Latency: 2 cycles per element with commit_ready_i held at 1. A run of N elements takes 2N+1 cycles from start acceptance to the done_o pulse.
- Arithmetic:
  - ADD and SUB are modulo 2^MEM_WIDTH; carry and borrow are discarded.
  - AND and XOR are bitwise.
  - Operands are unsigned bit vectors.
- start_i outside IDLE is ignored. op_i and len_i changes mid-run have no effect.
- The operand address outputs hold their last value outside FETCH. Nothing may depend on them there.
- idx never exceeds MEM_DEPTH-1. No wrap-around occurs because len_q is clamped.

Decomposition:
- Package op_engine_pkg holds:
  - typedef enum logic[1:0] op_e {OP_ADD, OP_SUB, OP_AND, OP_XOR};
  - typedef enum state_e {IDLE, FETCH, COMMIT, DONE};
- Sub-module op_alu: purely combinational, parameter MEM_WIDTH; inputs op_e and two operands; output the result. It is shared with the C reference model's operation encoding.

Test Plan:
- Reset and single element: op1[0]=7, op2[0]=5, op=ADD, len=1, ready=1.
  - One write: addr 0, data 12.
  - One commit: idx 0, data 12.
  - done_o pulses 3 cycles after start.
- Full SUB sweep with wrap: op1[i]=i, op2[i]=3, len=8.
  - mem[0]=0xFFFFFFFD … mem[7]=4.
  - 8 commits in order with idx 0..7.
- Backpressure: XOR, len=2, commit_ready_i held 0 for 5 cycles on element 0.
  - result_we_o high exactly once.
  - commit_data_o stable across the stall.
  - Total run takes 2·2+1+5 cycles.
- len boundaries:
  - len=0: done_o pulses on the second cycle, with no write and no commit.
  - len=15 with MEM_DEPTH=8: clamped to 8 commits.
- Ignored start and mid-run reset:
  - start_i pulsed in COMMIT: no restart; commit count unchanged.
  - rst_ni low in FETCH of element 3: all outputs 0 asynchronously; no write to idx 3; busy_o=0.
- AND with op change: op=AND, op1=0xF0F0F0F0, op2=0xFF00FF00, len=1, with op_i switched to ADD after start.
  - Result is 0xF000F000.

Source files
------------

// File: rtl/op_engine_pkg.sv
// Shared types for the two-operand element engine: ALU op encoding and FSM states.
package op_engine_pkg;

  // Operation encoding, shared with the C reference model.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  // Control states of the element walker.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/op_engine_alu.sv
// Combinational ALU: modulo add/sub, bitwise and/xor on unsigned operands.
module op_alu
  import op_engine_pkg::*;
#(
  parameter int MEM_WIDTH = 32
) (
  input  op_e                  op,
  input  logic [MEM_WIDTH-1:0] a,
  input  logic [MEM_WIDTH-1:0] b,
  output logic [MEM_WIDTH-1:0] res
);

  // Select the operation; carry and borrow simply fall off the top.
  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/op_engine.sv
// Walks len elements of two operand memories, writes op(a,b) to the result
// memory and streams each write as a commit record over valid/ready.
module op_engine
  import op_engine_pkg::*;
#(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      start_i,
  input  logic [1:0]                                op_i,
  input  logic [$clog2(MEM_DEPTH+1)-1:0]            len_i,
  output logic [((MEM_DEPTH>1)?$clog2(MEM_DEPTH):1)-1:0] operand1_addr_o,
  output logic [((MEM_DEPTH>1)?$clog2(MEM_DEPTH):1)-1:0] operand2_addr_o,
  input  logic [MEM_WIDTH-1:0]                      operand1_i,
  input  logic [MEM_WIDTH-1:0]                      operand2_i,
  output logic                                      result_we_o,
  output logic [((MEM_DEPTH>1)?$clog2(MEM_DEPTH):1)-1:0] result_addr_o,
  output logic [MEM_WIDTH-1:0]                      result_o,
  output logic                                      commit_valid_o,
  input  logic                                      commit_ready_i,
  output logic [((MEM_DEPTH>1)?$clog2(MEM_DEPTH):1)-1:0] commit_idx_o,
  output logic [MEM_WIDTH-1:0]                      commit_data_o,
  output logic                                      busy_o,
  output logic                                      done_o
);

  // A single-entry memory still needs one address bit.
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LW = $clog2(MEM_DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(MEM_DEPTH);

  state_e               state_q, state_d;
  logic [AW-1:0]        idx_q;
  op_e                  op_q;
  logic [LW-1:0]        len_q;
  logic [MEM_WIDTH-1:0] res_q;
  logic                 wr_done_q;   // element's result already written this COMMIT
  logic [LW-1:0]        len_clamp;
  logic                 last;
  logic                 handshake;
  logic [MEM_WIDTH-1:0] alu_res;

  // Clamp the requested length so idx can never run past the memory.
  assign len_clamp = (len_i > DEPTH_L) ? DEPTH_L : len_i;
  assign last      = (LW'(idx_q) == (len_q - LW'(1)));
  assign handshake = (state_q == COMMIT) && commit_ready_i;

  op_alu #(.MEM_WIDTH(MEM_WIDTH)) u_alu (
    .op  (op_q),
    .a   (operand1_i),
    .b   (operand2_i),
    .res (alu_res)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    state_d        = state_q;
    result_we_o    = 1'b0;
    commit_valid_o = 1'b0;
    busy_o         = 1'b1;
    done_o         = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = (len_clamp != '0) ? FETCH : DONE;
      end
      FETCH: begin
        state_d = COMMIT;
      end
      COMMIT: begin
        // Write only on the first COMMIT cycle so a stall never rewrites.
        result_we_o    = !wr_done_q;
        commit_valid_o = 1'b1;
        if (commit_ready_i) state_d = last ? DONE : FETCH;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Run configuration, element index, result register and write-once flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= OP_ADD;
      len_q     <= '0;
      idx_q     <= '0;
      res_q     <= '0;
      wr_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q  <= op_e'(op_i);
            len_q <= len_clamp;
            idx_q <= '0;
          end
        end
        FETCH: begin
          res_q     <= alu_res;
          wr_done_q <= 1'b0;
        end
        COMMIT: begin
          wr_done_q <= 1'b1;
          if (handshake && !last) idx_q <= idx_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Operand addresses follow idx, which only moves on a handshake or a
  // start, so they hold their value outside FETCH.
  assign operand1_addr_o = idx_q;
  assign operand2_addr_o = idx_q;
  assign result_addr_o   = idx_q;
  assign commit_idx_o    = idx_q;
  assign result_o        = res_q;
  assign commit_data_o   = res_q;

endmodule
